fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front end for the RISC-V core. It owns the program counter, drives the instruction memory address, and absorbs the memory's one-cycle read latency. Fetched words are buffered in a small queue and handed to the decode stage over a valid/ready handshake. It also accepts PC redirects from the execute stage for branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, PC issued first after reset; bits [1:0] must be 0
- DEPTH, 2, instruction queue entries; power of two, ≥2
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- imem_pc  out  32  fetch address to instruction memory
- imem_data  in  32  instruction word; valid one cycle after the matching imem_pc
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
- dec_valid  out  1  queue head holds a valid instruction
- dec_ready  in  1  decode accepts the head this cycle
- dec_instr  out  32  head instruction word
- dec_pc  out  32  PC of head instruction

## Operation
- State:
  - fetch_pc: the imem_pc register.
  - inflight_valid/inflight_pc: one outstanding read.
  - Queue: DEPTH entries of {pc, instr}, with head pointer, tail pointer and count.
- Issue: `issue = (count + inflight_valid - pop) < DEPTH`, where `pop = dec_valid & dec_ready`.
  - On issue: `inflight_valid <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`.
  - Otherwise fetch_pc holds and `inflight_valid <= 0`.
- PC arithmetic: 32-bit, modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- Return: if inflight_valid, push {inflight_pc, imem_data} at the tail. imem_data is ignored whenever inflight_valid = 0.
- Push and pop in the same cycle leave count unchanged. Overflow is unreachable by the credit rule; the bench asserts it never occurs.
- dec_valid = (count != 0). dec_instr and dec_pc come from registered queue storage; there is no combinational path from imem_data.
- Redirect has highest priority. When redirect_valid = 1 in cycle N:
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Queue is emptied and `inflight_valid <= 0`, so the data returning in cycle N+1 is dropped.
  - A pop in cycle N still counts as a completed transfer.
  - No issue is counted in cycle N.
- Back-to-back redirects: the last one wins.

## Timing
- Reset values: imem_pc = RESET_PC, dec_valid = 0, dec_instr = 0, dec_pc = 0, count = 0, inflight_valid = 0.
- Reset mid-operation: outputs take their reset values immediately (asynchronously), and all in-flight data is lost.
- Cycle 0 is the first cycle after reset deasserts. RESET_PC is issued in cycle 0, its data arrives in cycle 1, and dec_valid is 1 in cycle 2.
- Fetch-to-decode latency is 2 cycles.
- Throughput is 1 instruction/cycle when dec_ready is held high, for any DEPTH ≥ 2.
- Redirect penalty: redirect in cycle N gives dec_valid = 0 in N+1 and N+2; the target instruction appears in N+3.
- dec_instr and dec_pc are stable while `dec_valid & ~dec_ready`.

## Structure
- Package rv_core_pkg:
  - XLEN = 32, INSTR_BYTES = 4.
  - Typedef fetch_entry_t = {pc[31:0], instr[31:0]}.
- Sub-module fetch_queue: circular buffer with push, pop, flush, count, and head outputs, parameterised on DEPTH.
- The top level holds the PC register, in-flight tracking and credit logic.

## Test plan
- **Reset and stream:** memory holds 0x00940333 at 0 and 0x413903b3 at 4, RESET_PC = 0, dec_ready = 1 → cycle 2 shows dec_pc = 0 / dec_instr = 0x00940333, cycle 3 shows dec_pc = 4 / 0x413903b3, then one instruction per cycle.
- **Backpressure:** dec_ready = 0 for cycles 2–7 → dec_pc holds 0, the queue holds PCs 0 and 4, and imem_pc stalls at 8. After release, dec_pc sequence is 0, 4, 8, 12 with no gaps or duplicates.
- **Redirect:** redirect_valid = 1, redirect_pc = 0x20 in cycle 5 → dec_valid = 0 in cycles 6–7, imem_pc = 0x20 in cycle 6, dec_pc = 0x20 / dec_instr = 0x0020a533 in cycle 8.
- **Misaligned redirect plus pop:** redirect_pc = 0x22 in the same cycle as a pop → fetch restarts at 0x20, and the popped entry is counted as delivered exactly once.
- **Wrap:** RESET_PC = 0xFFFF_FFFC → imem_pc = 0x0000_0000 in cycle 1, and dec_pc = 0x0 follows 0xFFFF_FFFC.
- **Async reset mid-stream:** assert reset between clock edges in cycle 10 → dec_valid = 0 and imem_pc = RESET_PC before the next edge; after release, cycle 2 shows dec_pc = RESET_PC again.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared core widths and the fetch queue entry type.
package rv_core_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular buffer of fetched {pc, instr} entries.
// Flush has priority over push/pop; head outputs come straight from registered storage.
module fetch_queue
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [XLEN-1:0]         push_pc,
   input  logic [XLEN-1:0]         push_instr,
   input  logic                    pop,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  count,
   output logic [XLEN-1:0]         head_pc,
   output logic [XLEN-1:0]         head_instr
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = '{pc: push_pc, instr: push_instr};
            tail_d        = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign head_pc    = mem_q[head_q].pc;
   assign head_instr = mem_q[head_q].instr;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, one in-flight read, decode queue.
// A read is only issued when the queue is guaranteed a free slot for its return.
module fetch_stage
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_valid_q, inflight_valid_d;

   logic [CW-1:0] count;
   logic [CW:0]   credit_used;
   logic          pop;
   logic          push;
   logic          issue;

   assign dec_valid   = (count != '0);
   assign pop         = dec_valid & dec_ready;
   // A redirect kills the returning word, so it never lands in the flushed queue.
   assign push        = inflight_valid_q & ~redirect_valid;
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_valid_q} - {{CW{1'b0}}, pop};
   assign issue       = ~redirect_valid & (credit_used < DEPTH_W);

   always_comb begin
      fetch_pc_d       = fetch_pc_q;
      inflight_pc_d    = inflight_pc_q;
      inflight_valid_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         inflight_valid_d = 1'b1;
         inflight_pc_d    = fetch_pc_q;
         fetch_pc_d       = fetch_pc_q + XLEN'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q       <= RESET_PC & ALIGN_MASK;
         inflight_pc_q    <= '0;
         inflight_valid_q <= 1'b0;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_valid_q <= inflight_valid_d;
      end
   end

   assign imem_pc = fetch_pc_q;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_pc    (inflight_pc_q),
      .push_instr (imem_data),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head_pc    (dec_pc),
      .head_instr (dec_instr)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage plus a wrap-around instance.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic [31:0] imem_data;
   logic [31:0] imem_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;

   logic        w_reset;
   logic        w_redirect_valid = 1'b0;
   logic [31:0] w_redirect_pc    = 32'h0;
   logic        w_dec_ready      = 1'b1;
   logic [31:0] w_imem_data;
   logic [31:0] w_imem_pc;
   logic        w_dec_valid;
   logic [31:0] w_dec_instr;
   logic [31:0] w_dec_pc;

   int checks   = 0;
   int failures = 0;
   int cyc;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_pc        (imem_pc),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
      .clock          (clock),
      .reset          (w_reset),
      .imem_pc        (w_imem_pc),
      .imem_data      (w_imem_data),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .dec_valid      (w_dec_valid),
      .dec_ready      (w_dec_ready),
      .dec_instr      (w_dec_instr),
      .dec_pc         (w_dec_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0094_0333;
         32'h0000_0004: return 32'h4139_03b3;
         32'h0000_0020: return 32'h0020_a533;
         default:       return {a[23:0], 8'h13} ^ 32'h0050_0000;
      endcase
   endfunction

   // Instruction memory with one cycle of read latency.
   always @(posedge clock) begin
      imem_data   <= mem_word(imem_pc);
      w_imem_data <= mem_word(w_imem_pc);
   end

   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_q.push_back('{pc, mem_word(pc)});
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #2;
   endtask

   task automatic apply_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      dec_ready      = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
   endtask

   task automatic scenario_end(input string name);
      check32(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: every accepted transfer must match the head of the expected queue.
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b0 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected cycle=%0d actual_pc=%h expected=none", cyc, dec_pc);
         end else begin
            e = exp_q.pop_front();
            check32("sb_pc", dec_pc, e.pc);
            check32("sb_instr", dec_instr, e.instr);
         end
      end
      if (reset === 1'b0 && dut.u_queue.push && !dut.u_queue.pop && dut.u_queue.count == 2) begin
         failures++;
         $display("FAIL queue_overflow cycle=%0d actual_count=%0d required=<2", cyc, dut.u_queue.count);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1);
   end

   initial begin
      reset          = 1'b1;
      w_reset        = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      dec_ready      = 1'b0;
      #12;
      check32("rst_imem_pc", imem_pc, 32'h0);
      check32("rst_dec_valid", dec_valid, 0);
      check32("rst_dec_instr", dec_instr, 32'h0);
      check32("rst_dec_pc", dec_pc, 32'h0);
      check32("rst_wrap_imem_pc", w_imem_pc, 32'hFFFF_FFFC);

      // Stream from reset, plus the wrap-around instance.
      @(posedge clock);
      #2;
      reset     = 1'b0;
      w_reset   = 1'b0;
      dec_ready = 1'b1;
      for (int k = 0; k < 6; k++) expect_pc(4 * k);
      for (int c = 0; c <= 7; c++) begin
         @(negedge clock);
         if (c < 2)  check32("a_valid_early", dec_valid, 0);
         if (c == 0) check32("a_imem_pc0", imem_pc, 32'h0);
         if (c == 2) check32("a_valid_c2", dec_valid, 1);
         if (c == 1) check32("wrap_imem_pc", w_imem_pc, 32'h0);
         if (c == 2) check32("wrap_dec_pc_c2", w_dec_pc, 32'hFFFF_FFFC);
         if (c == 3) check32("wrap_dec_pc_c3", w_dec_pc, 32'h0);
         if (c == 3) check32("wrap_valid_c3", w_dec_valid, 1);
         next_cycle();
      end
      scenario_end("a_drained");

      // Backpressure: decode stalls through cycle 7.
      apply_reset();
      for (int k = 0; k < 4; k++) expect_pc(4 * k);
      for (int c = 0; c <= 11; c++) begin
         dec_ready = (c >= 8);
         @(negedge clock);
         if (c >= 3 && c <= 7) begin
            check32("b_hold_pc", dec_pc, 32'h0);
            check32("b_hold_valid", dec_valid, 1);
            check32("b_stall_imem", imem_pc, 32'h8);
         end
         if (c == 9) check32("b_resume_imem", imem_pc, 32'hC);
         next_cycle();
      end
      scenario_end("b_drained");

      // Aligned redirect in cycle 5.
      apply_reset();
      dec_ready   = 1'b1;
      redirect_pc = 32'h20;
      foreach (exp_q[i]) ;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
      expect_pc(32'h20); expect_pc(32'h24); expect_pc(32'h28);
      for (int c = 0; c <= 10; c++) begin
         redirect_valid = (c == 5);
         @(negedge clock);
         if (c == 6 || c == 7) check32("c_bubble", dec_valid, 0);
         if (c == 6) check32("c_imem_target", imem_pc, 32'h20);
         if (c == 8) check32("c_dec_pc", dec_pc, 32'h20);
         if (c == 8) check32("c_dec_instr", dec_instr, 32'h0020_a533);
         next_cycle();
      end
      redirect_valid = 1'b0;
      scenario_end("c_drained");

      // Misaligned redirect with a pop, then back-to-back redirects.
      apply_reset();
      dec_ready = 1'b1;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
      expect_pc(32'h20); expect_pc(32'h24); expect_pc(32'h28); expect_pc(32'h2C);
      expect_pc(32'h60); expect_pc(32'h64);
      for (int c = 0; c <= 15; c++) begin
         redirect_valid = (c == 4 || c == 10 || c == 11);
         redirect_pc    = (c == 4) ? 32'h22 : (c == 10) ? 32'h40 : 32'h60;
         @(negedge clock);
         if (c == 4) check32("d_pop_with_redirect", dec_valid, 1);
         if (c == 5) check32("d_imem_aligned", imem_pc, 32'h20);
         if (c == 5 || c == 6) check32("d_bubble1", dec_valid, 0);
         if (c == 11) check32("d_imem_first", imem_pc, 32'h40);
         if (c == 12) check32("d_imem_last_wins", imem_pc, 32'h60);
         if (c >= 11 && c <= 13) check32("d_bubble2", dec_valid, 0);
         if (c == 14) check32("d_dec_pc", dec_pc, 32'h60);
         next_cycle();
      end
      redirect_valid = 1'b0;
      scenario_end("d_drained");

      // Asynchronous reset in the middle of cycle 10.
      apply_reset();
      dec_ready = 1'b1;
      for (int k = 0; k < 8; k++) expect_pc(4 * k);
      for (int c = 0; c <= 9; c++) begin
         @(negedge clock);
         next_cycle();
      end
      #1;
      reset = 1'b1;
      #1;
      check32("e_async_valid", dec_valid, 0);
      check32("e_async_imem_pc", imem_pc, 32'h0);
      check32("e_async_dec_pc", dec_pc, 32'h0);
      check32("e_async_dec_instr", dec_instr, 32'h0);
      scenario_end("e_drained_before");
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      expect_pc(32'h0);
      expect_pc(32'h4);
      for (int c = 0; c <= 3; c++) begin
         @(negedge clock);
         if (c == 2) check32("e_restart_pc", dec_pc, 32'h0);
         next_cycle();
      end
      dec_ready = 1'b0;
      repeat (3) next_cycle();
      scenario_end("e_drained_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
